// File: rtl/fpu_mc_sequencer_if.sv
// Purpose: bundles the E-stage issue, decode hazard, FP-unit and writeback signals of the sequencer.
// Latency: none (wires only).
// Backpressure: stall_req from the sequencer freezes F/D; wb_pipe_busy holds off the sequencer write.
// Modports: master = pipeline/unit side (drives issue, decode, unit reply, pipe-busy);
//           slave  = sequencer side (drives unit start/operands, writeback, stall and status).
interface fpu_mc_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    // E-stage issue
    logic          issue_valid_E;
    logic          flushE;
    logic [3:0]    fpu_control_E;
    logic [AW-1:0] rdE;
    logic [DW-1:0] srcA_E;
    logic [DW-1:0] srcB_E;
    // decode-stage register fields for hazard detection
    logic [AW-1:0] rs1D;
    logic [AW-1:0] rs2D;
    logic [AW-1:0] rdD;
    logic          rd1_selD;
    logic          rd2_selD;
    logic          rdW_selD;
    logic          reg_writeD;
    // multi-cycle unit handshake
    logic          mc_start;
    logic [3:0]    mc_op;
    logic [DW-1:0] mc_a;
    logic [DW-1:0] mc_b;
    logic          mc_done;
    logic [DW-1:0] mc_result;
    // float register-file write port arbitration
    logic          wb_pipe_busy;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    // hazard unit / status
    logic          stall_req;
    logic          busy;
    logic          timeout_err;

    modport master (
        output issue_valid_E, flushE, fpu_control_E, rdE, srcA_E, srcB_E,
        output rs1D, rs2D, rdD, rd1_selD, rd2_selD, rdW_selD, reg_writeD,
        output mc_done, mc_result, wb_pipe_busy,
        input  mc_start, mc_op, mc_a, mc_b,
        input  wb_en, wb_addr, wb_data, stall_req, busy, timeout_err
    );

    modport slave (
        input  issue_valid_E, flushE, fpu_control_E, rdE, srcA_E, srcB_E,
        input  rs1D, rs2D, rdD, rd1_selD, rd2_selD, rdW_selD, reg_writeD,
        input  mc_done, mc_result, wb_pipe_busy,
        output mc_start, mc_op, mc_a, mc_b,
        output wb_en, wb_addr, wb_data, stall_req, busy, timeout_err
    );
endinterface

// File: rtl/fpu_mc_sequencer.sv
// Purpose: issue/completion controller for a multi-cycle FP divide/sqrt unit with a one-entry
//          float-destination scoreboard and float write-port arbitration against pipeline W.
// Latency: mc_start the cycle after issue; wb_en earliest the cycle after mc_done; IDLE after the wb_en edge.
// Backpressure: stall_req holds F/D while an op is pending; the pipeline owns the write port (wb_pipe_busy).
// Ports: clk, reset (synchronous, active-high); bus = fpu_mc_if.slave (issue, decode fields, unit
//        handshake, writeback, stall_req/busy/timeout_err).
// Option: FPU_SEQ_PERF_EN adds saturating perf_busy_cycles / perf_stall_cycles outputs.
module fpu_mc_sequencer #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    fpu_mc_if.slave     bus
`ifdef FPU_SEQ_PERF_EN
    ,
    output logic [31:0] perf_busy_cycles,
    output logic [31:0] perf_stall_cycles
`endif
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] cnt;
    logic          mc_start_q;
    logic [3:0]    mc_op_q;
    logic [DW-1:0] mc_a_q;
    logic [DW-1:0] mc_b_q;
    logic [AW-1:0] pend_rd;
    logic [DW-1:0] wb_data_q;
    logic          timeout_err_q;

    logic          busy;
    logic          wb_en;
    logic          stall_req;
    logic          issue_acc;
    logic          run_expire;
    logic          raw_hit;
    logic          waw_hit;

    // A flushed E instruction never reaches the unit.
    assign issue_acc  = bus.issue_valid_E & ~bus.flushE;
    assign run_expire = (cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; mc_done wins over the timeout on the same edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (issue_acc) state_nxt = S_RUN;
            S_RUN: begin
                if (bus.mc_done)     state_nxt = S_WB;
                else if (run_expire) state_nxt = S_IDLE;
            end
            S_WB:   if (wb_en) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic; float x0 is an ordinary register so no zero-address masking.
    always_comb begin
        busy      = (state != S_IDLE);
        wb_en     = (state == S_WB) & ~bus.wb_pipe_busy;
        raw_hit   = (bus.rd1_selD & (bus.rs1D == pend_rd)) |
                    (bus.rd2_selD & (bus.rs2D == pend_rd));
        waw_hit   = bus.reg_writeD & bus.rdW_selD & (bus.rdD == pend_rd);
        stall_req = busy & (bus.issue_valid_E | raw_hit | waw_hit);
    end

    // Datapath: operand/destination latch, run counter, result capture, sticky abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            mc_start_q    <= 1'b0;
            mc_op_q       <= '0;
            mc_a_q        <= '0;
            mc_b_q        <= '0;
            pend_rd       <= '0;
            wb_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            mc_start_q <= (state == S_IDLE) & issue_acc;
            if ((state == S_IDLE) & issue_acc) begin
                mc_op_q <= bus.fpu_control_E;
                mc_a_q  <= bus.srcA_E;
                mc_b_q  <= bus.srcB_E;
                pend_rd <= bus.rdE;
                cnt     <= '0;
            end else if ((state == S_RUN) & ~bus.mc_done & ~run_expire) begin
                // Abort fires at TIMEOUT-1, so the counter never wraps.
                cnt <= cnt + CW'(1);
            end
            if ((state == S_RUN) & bus.mc_done) begin
                wb_data_q <= bus.mc_result;
            end
            if ((state == S_RUN) & ~bus.mc_done & run_expire) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign bus.mc_start    = mc_start_q;
    assign bus.mc_op       = mc_op_q;
    assign bus.mc_a        = mc_a_q;
    assign bus.mc_b        = mc_b_q;
    assign bus.wb_en       = wb_en;
    assign bus.wb_addr     = pend_rd;
    assign bus.wb_data     = wb_data_q;
    assign bus.stall_req   = stall_req;
    assign bus.busy        = busy;
    assign bus.timeout_err = timeout_err_q;

`ifdef FPU_SEQ_PERF_EN
    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (stall_req && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
